// File: rtl/execute_stage_mdu_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_mdu_if
// Purpose  : ID/EX-side inputs and EX/MEM-side outputs of the RV32IM execute stage.
// Revision : 1.0 - initial release
// ============================================================================
interface execute_stage_mdu_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              flush, in_valid, in_ready;
    logic              ctl_alusrc, ctl_memtoreg, ctl_regwrite, ctl_memread, ctl_memwrite, ctl_branch;
    logic [1:0]        ctl_aluop;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              jal_in, jalr_in;
    logic [REG_AW-1:0] rd_in;
    logic [XLEN-1:0]   imm_in, rs1_data, rs2_data, pc_in, mem_fwd_data, wb_fwd_data;
    logic [1:0]        fwd_a, fwd_b;
    logic              out_valid;
    logic              memtoreg_out, regwrite_out, memread_out, memwrite_out, branch_out, jal_out, jalr_out;
    logic              branch_taken, illegal_out;
    logic [REG_AW-1:0] rd_out;
    logic [XLEN-1:0]   alu_result_out, pcimm_out, rs2_data_out, pc_out;

    modport slave (
        input  flush, in_valid, ctl_alusrc, ctl_memtoreg, ctl_regwrite, ctl_memread, ctl_memwrite,
               ctl_branch, ctl_aluop, funct3, funct7, jal_in, jalr_in, rd_in, imm_in, rs1_data,
               rs2_data, pc_in, mem_fwd_data, wb_fwd_data, fwd_a, fwd_b,
        output in_ready, out_valid, memtoreg_out, regwrite_out, memread_out, memwrite_out,
               branch_out, jal_out, jalr_out, branch_taken, illegal_out, rd_out, alu_result_out,
               pcimm_out, rs2_data_out, pc_out
    );

    modport master (
        output flush, in_valid, ctl_alusrc, ctl_memtoreg, ctl_regwrite, ctl_memread, ctl_memwrite,
               ctl_branch, ctl_aluop, funct3, funct7, jal_in, jalr_in, rd_in, imm_in, rs1_data,
               rs2_data, pc_in, mem_fwd_data, wb_fwd_data, fwd_a, fwd_b,
        input  in_ready, out_valid, memtoreg_out, regwrite_out, memread_out, memwrite_out,
               branch_out, jal_out, jalr_out, branch_taken, illegal_out, rd_out, alu_result_out,
               pcimm_out, rs2_data_out, pc_out
    );
endinterface
`default_nettype wire

// File: rtl/execute_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_mdu
// Purpose  : RV32IM execute stage + EX/MEM register with iterative mul/div unit.
//            Define EXECUTE_MDU_DIV_EN to build the divider (div/divu/rem/remu).
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage_mdu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               reset,
    execute_stage_mdu_if.slave bus
);
    localparam int            SHW    = $clog2(XLEN);
    localparam int            CW     = SHW + 1;
    localparam logic [CW-1:0] C_LAST = CW'(XLEN);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3, OP_SLTU = 4'd4,
        OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_OR = 4'd8, OP_AND = 4'd9
    } alu_op_t;
    typedef struct packed {
        logic              memtoreg, regwrite, memread, memwrite, branch, jal, jalr, taken, illegal;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   res, pcimm, rs2, pc;
    } exmem_t;

    function automatic alu_op_t f3_op(input logic [2:0] f3, input logic arith);
        case (f3)
            3'b000:  f3_op = OP_ADD;
            3'b001:  f3_op = OP_SLL;
            3'b010:  f3_op = OP_SLT;
            3'b011:  f3_op = OP_SLTU;
            3'b100:  f3_op = OP_XOR;
            3'b101:  f3_op = arith ? OP_SRA : OP_SRL;
            3'b110:  f3_op = OP_OR;
            default: f3_op = OP_AND;
        endcase
    endfunction

    // Bubble: control cleared, data fields held.
    function automatic exmem_t bubble(input exmem_t p);
        exmem_t b;
        b = p;
        {b.memtoreg, b.regwrite, b.memread, b.memwrite, b.branch, b.jal, b.jalr, b.taken, b.illegal} = '0;
        return b;
    endfunction

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] acc_q, lo_q, mcand_q;
    logic            neg_q, valid_q;
    exmem_t          pend_q, exmem_q, w_pkt;
`ifdef EXECUTE_MDU_DIV_EN
    logic            neg_rem_q, dz_q, w_is_div;
    logic [XLEN-1:0] dvd_q;
`endif

    logic [XLEN-1:0] w_a, w_rs2, w_b, w_alu, w_a_mag, w_b_mag;
    logic [SHW-1:0]  w_shamt;
    logic            w_lt, w_ltu, w_taken, w_illegal, w_is_br, w_is_mul, w_is_mdu, w_accept;
    logic            w_a_neg, w_b_neg;
    alu_op_t         w_op;

    assign w_a   = (bus.fwd_a == 2'b10) ? bus.mem_fwd_data : (bus.fwd_a == 2'b01) ? bus.wb_fwd_data : bus.rs1_data;
    assign w_rs2 = (bus.fwd_b == 2'b10) ? bus.mem_fwd_data : (bus.fwd_b == 2'b01) ? bus.wb_fwd_data : bus.rs2_data;
    assign w_b   = bus.ctl_alusrc ? bus.imm_in : w_rs2;

    always_comb begin
        w_op      = OP_ADD;
        w_illegal = 1'b0;
        w_is_br   = 1'b0;
        w_is_mul  = 1'b0;
`ifdef EXECUTE_MDU_DIV_EN
        w_is_div  = 1'b0;
`endif
        case (bus.ctl_aluop)
            2'b00: w_op = OP_ADD;
            2'b01: begin
                w_op      = OP_SUB;
                w_is_br   = 1'b1;
                w_illegal = (bus.funct3[2:1] == 2'b01);
            end
            2'b10: begin
                if (bus.funct7 == 7'b0000001) begin
                    if (!bus.funct3[2])
                        w_is_mul = 1'b1;
                    else
`ifdef EXECUTE_MDU_DIV_EN
                        w_is_div = 1'b1;
`else
                        w_illegal = 1'b1;
`endif
                end else if (bus.funct7 == 7'b0000000)
                    w_op = f3_op(bus.funct3, 1'b0);
                else if (bus.funct7 == 7'b0100000 && bus.funct3 == 3'b000)
                    w_op = OP_SUB;
                else if (bus.funct7 == 7'b0100000 && bus.funct3 == 3'b101)
                    w_op = OP_SRA;
                else
                    w_illegal = 1'b1;
            end
            default: w_op = f3_op(bus.funct3, bus.funct7[5]);
        endcase
    end

    always_comb begin
        w_shamt = w_b[SHW-1:0];
        w_lt    = $signed(w_a) < $signed(w_b);
        w_ltu   = w_a < w_b;
        case (w_op)
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_SLL:  w_alu = w_a << w_shamt;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_ltu};
            OP_XOR:  w_alu = w_a ^ w_b;
            OP_SRL:  w_alu = w_a >> w_shamt;
            OP_SRA:  w_alu = $signed(w_a) >>> w_shamt;
            OP_OR:   w_alu = w_a | w_b;
            default: w_alu = w_a & w_b;
        endcase
        case (bus.funct3)
            3'b000:  w_taken = (w_a == w_b);
            3'b001:  w_taken = (w_a != w_b);
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = !w_lt;
            3'b110:  w_taken = w_ltu;
            3'b111:  w_taken = !w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_pkt.memtoreg = bus.ctl_memtoreg;
        w_pkt.regwrite = bus.ctl_regwrite & ~w_illegal;
        w_pkt.memread  = bus.ctl_memread;
        w_pkt.memwrite = bus.ctl_memwrite;
        w_pkt.branch   = bus.ctl_branch;
        w_pkt.jal      = bus.jal_in;
        w_pkt.jalr     = bus.jalr_in;
        w_pkt.taken    = w_is_br & w_taken & ~w_illegal;
        w_pkt.illegal  = w_illegal;
        w_pkt.rd       = bus.rd_in;
        w_pkt.res      = w_illegal ? '0 : w_alu;
        w_pkt.pcimm    = bus.pc_in + (bus.imm_in << 1);
        w_pkt.rs2      = w_rs2;
        w_pkt.pc       = bus.pc_in;
    end

    // Signed ops iterate on magnitudes; the sign is restored in the final MUL/DIV cycle.
    assign w_a_neg = ((bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) | (bus.funct3 == 3'b100) |
                      (bus.funct3 == 3'b110)) & w_a[XLEN-1];
    assign w_b_neg = ((bus.funct3 == 3'b001) | (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110)) & w_b[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a : w_a;
    assign w_b_mag = w_b_neg ? -w_b : w_b;

    logic [XLEN:0]     w_madd;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;
    assign w_madd    = {1'b0, acc_q} + {1'b0, {XLEN{lo_q[0]}} & mcand_q};
    assign w_prod    = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    assign w_mul_res = (op_q == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef EXECUTE_MDU_DIV_EN
    logic [XLEN:0]   w_rs;
    logic [XLEN+1:0] w_diff;
    logic [XLEN-1:0] w_quo, w_rem;
    assign w_rs     = {acc_q, lo_q[XLEN-1]};
    assign w_diff   = {1'b0, w_rs} - {2'b00, mcand_q};
    assign w_quo    = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
    assign w_rem    = dz_q ? dvd_q : (neg_rem_q ? -acc_q : acc_q);
    assign w_is_mdu = w_is_mul | w_is_div;
`else
    assign w_is_mdu = w_is_mul;
`endif

    assign bus.in_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign w_accept     = bus.in_valid & bus.in_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            pend_q  <= '0;
            exmem_q <= '0;
            valid_q <= 1'b0;
`ifdef EXECUTE_MDU_DIV_EN
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            dvd_q     <= '0;
`endif
        end else if (bus.flush) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            exmem_q <= bubble(exmem_q);
        end else begin
            valid_q <= 1'b0;
            exmem_q <= bubble(exmem_q);
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_DONE) begin
                        valid_q <= 1'b1;
                        exmem_q <= pend_q;
                        state_q <= S_IDLE;
                    end
                    if (w_accept) begin
                        if (w_is_mdu) begin
                            pend_q  <= w_pkt;
                            op_q    <= bus.funct3[1:0];
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            neg_q   <= w_a_neg ^ w_b_neg;
                            state_q <= S_MUL;
                            lo_q    <= w_b_mag;
                            mcand_q <= w_a_mag;
`ifdef EXECUTE_MDU_DIV_EN
                            if (w_is_div) begin
                                state_q   <= S_DIV;
                                lo_q      <= w_a_mag;
                                mcand_q   <= w_b_mag;
                                neg_rem_q <= w_a_neg;
                                dz_q      <= (w_b == '0);
                                dvd_q     <= w_a;
                            end
`endif
                        end else if (state_q == S_IDLE) begin
                            exmem_q <= w_pkt;
                            valid_q <= 1'b1;
                        end else begin
                            // EX/MEM is busy with the MDU result: replay this op from DONE.
                            pend_q  <= w_pkt;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == C_LAST) begin
                        pend_q.res <= w_mul_res;
                        state_q    <= S_DONE;
                    end else begin
                        acc_q <= w_madd[XLEN:1];
                        lo_q  <= {w_madd[0], lo_q[XLEN-1:1]};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`ifdef EXECUTE_MDU_DIV_EN
                S_DIV: begin
                    if (cnt_q == C_LAST) begin
                        pend_q.res <= op_q[1] ? w_rem : w_quo;
                        state_q    <= S_DONE;
                    end else begin
                        acc_q <= w_diff[XLEN+1] ? w_rs[XLEN-1:0] : w_diff[XLEN-1:0];
                        lo_q  <= {lo_q[XLEN-2:0], ~w_diff[XLEN+1]};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.memtoreg_out   = exmem_q.memtoreg;
    assign bus.regwrite_out   = exmem_q.regwrite;
    assign bus.memread_out    = exmem_q.memread;
    assign bus.memwrite_out   = exmem_q.memwrite;
    assign bus.branch_out     = exmem_q.branch;
    assign bus.jal_out        = exmem_q.jal;
    assign bus.jalr_out       = exmem_q.jalr;
    assign bus.branch_taken   = exmem_q.taken;
    assign bus.illegal_out    = exmem_q.illegal;
    assign bus.rd_out         = exmem_q.rd;
    assign bus.alu_result_out = exmem_q.res;
    assign bus.pcimm_out      = exmem_q.pcimm;
    assign bus.rs2_data_out   = exmem_q.rs2;
    assign bus.pc_out         = exmem_q.pc;
endmodule
`default_nettype wire

// File: tb/tb_execute_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage_mdu
// Purpose  : Directed-vector bench for execute_stage_mdu (ALU, branch, MDU, flush).
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage_mdu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    execute_stage_mdu_if #(.XLEN(32), .REG_AW(5)) u_if ();
    execute_stage_mdu #(.XLEN(32), .REG_AW(5)) u_dut (.clk(clk), .reset(reset), .bus(u_if));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        u_if.flush = 0; u_if.in_valid = 0;
        u_if.ctl_alusrc = 0; u_if.ctl_memtoreg = 0; u_if.ctl_regwrite = 0;
        u_if.ctl_memread = 0; u_if.ctl_memwrite = 0; u_if.ctl_branch = 0;
        u_if.ctl_aluop = 2'b00; u_if.funct3 = 3'b000; u_if.funct7 = 7'b0;
        u_if.jal_in = 0; u_if.jalr_in = 0; u_if.rd_in = 5'd0;
        u_if.imm_in = 0; u_if.rs1_data = 0; u_if.rs2_data = 0; u_if.pc_in = 0;
        u_if.mem_fwd_data = 0; u_if.wb_fwd_data = 0; u_if.fwd_a = 2'b00; u_if.fwd_b = 2'b00;
    endtask

    task automatic op(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b);
        idle();
        u_if.in_valid = 1; u_if.ctl_aluop = aluop; u_if.funct3 = f3; u_if.funct7 = f7;
        u_if.rs1_data = a; u_if.rs2_data = b; u_if.rd_in = 5'd7; u_if.pc_in = 32'h1000;
        u_if.ctl_branch = (aluop == 2'b01); u_if.ctl_regwrite = (aluop != 2'b01);
    endtask

    // Accept on the next edge, then wait for the MDU result with a bounded loop.
    task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int edges = 0;
        int low = 0;
        op(2'b10, f3, 7'b0000001, a, b);
        tick();
        u_if.in_valid = 0;
        while (!u_if.out_valid && edges < 60) begin
            if (!u_if.in_ready) low++;
            tick();
            edges++;
        end
        chk({tag, " latency"}, edges, 34);
        chk({tag, " stall"}, low, 33);
        chk({tag, " result"}, u_if.alu_result_out, exp);
        chk({tag, " regwrite"}, {31'b0, u_if.regwrite_out}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int late;
        idle();
        reset = 1;
        tick(); tick();
        chk("rst out_valid", {31'b0, u_if.out_valid}, 0);
        chk("rst alu", u_if.alu_result_out, 0);
        chk("rst regwrite", {31'b0, u_if.regwrite_out}, 0);
        chk("rst in_ready", {31'b0, u_if.in_ready}, 1);
        reset = 0;

        op(2'b10, 3'b000, 7'b0, 32'd5, 32'd7); u_if.imm_in = 32'h10;
        tick();
        chk("add alu", u_if.alu_result_out, 12);
        chk("add valid", {31'b0, u_if.out_valid}, 1);
        chk("add regwrite", {31'b0, u_if.regwrite_out}, 1);
        chk("add pcimm", u_if.pcimm_out, 32'h1020);
        chk("add rd", {27'b0, u_if.rd_out}, 7);

        idle(); tick();
        chk("bubble valid", {31'b0, u_if.out_valid}, 0);
        chk("bubble regwrite", {31'b0, u_if.regwrite_out}, 0);
        chk("bubble held", u_if.alu_result_out, 12);

        op(2'b11, 3'b000, 7'b0, 32'd10, 32'd0); u_if.ctl_alusrc = 1; u_if.imm_in = 32'hFFFF_FFFC;
        tick(); chk("addi", u_if.alu_result_out, 6);
        op(2'b11, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0); u_if.ctl_alusrc = 1; u_if.imm_in = 32'h404;
        tick(); chk("srai", u_if.alu_result_out, 32'hF800_0000);
        op(2'b10, 3'b101, 7'b0, 32'h8000_0000, 32'd4);
        tick(); chk("srl", u_if.alu_result_out, 32'h0800_0000);
        op(2'b10, 3'b001, 7'b0, 32'd1, 32'd33);
        tick(); chk("sll wrap", u_if.alu_result_out, 2);
        op(2'b10, 3'b010, 7'b0, 32'hFFFF_FFFF, 32'd1);
        tick(); chk("slt", u_if.alu_result_out, 1);
        op(2'b10, 3'b011, 7'b0, 32'hFFFF_FFFF, 32'd1);
        tick(); chk("sltu", u_if.alu_result_out, 0);
        op(2'b10, 3'b111, 7'b0, 32'hF0F0, 32'hFF00);
        tick(); chk("and", u_if.alu_result_out, 32'hF000);
        op(2'b10, 3'b001, 7'b0100000, 32'd3, 32'd4);
        tick();
        chk("illegal flag", {31'b0, u_if.illegal_out}, 1);
        chk("illegal regwrite", {31'b0, u_if.regwrite_out}, 0);
        chk("illegal alu", u_if.alu_result_out, 0);

        op(2'b10, 3'b000, 7'b0100000, 32'h999, 32'd3); u_if.fwd_a = 2'b10; u_if.mem_fwd_data = 32'h10;
        tick(); chk("fwd sub", u_if.alu_result_out, 32'h0D);
        op(2'b00, 3'b000, 7'b0, 32'd1, 32'd3); u_if.ctl_alusrc = 1; u_if.imm_in = 32'd8;
        u_if.fwd_b = 2'b01; u_if.wb_fwd_data = 32'h20;
        tick();
        chk("fwd imm alu", u_if.alu_result_out, 9);
        chk("fwd rs2 out", u_if.rs2_data_out, 32'h20);

        op(2'b01, 3'b110, 7'b0, 32'd1, 32'hFFFF_FFFF);
        tick();
        chk("bltu taken", {31'b0, u_if.branch_taken}, 1);
        chk("bltu alu", u_if.alu_result_out, 2);
        chk("bltu branch_out", {31'b0, u_if.branch_out}, 1);
        op(2'b01, 3'b100, 7'b0, 32'd1, 32'hFFFF_FFFF);
        tick(); chk("blt taken", {31'b0, u_if.branch_taken}, 0);
        op(2'b01, 3'b101, 7'b0, 32'd5, 32'd5);
        tick(); chk("bge taken", {31'b0, u_if.branch_taken}, 1);
        op(2'b01, 3'b001, 7'b0, 32'd3, 32'd4);
        tick(); chk("bne taken", {31'b0, u_if.branch_taken}, 1);
        op(2'b01, 3'b000, 7'b0, 32'd3, 32'd4);
        tick(); chk("beq taken", {31'b0, u_if.branch_taken}, 0);

        run_mdu("mulh", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        tick(); chk("mdu one-shot", {31'b0, u_if.out_valid}, 0);
        run_mdu("mul", 3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
        run_mdu("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mdu("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

`ifdef EXECUTE_MDU_DIV_EN
        run_mdu("div by0", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_mdu("rem by0", 3'b110, 32'd7, 32'd0, 32'd7);
        run_mdu("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_mdu("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_mdu("div neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_mdu("rem neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_mdu("divu", 3'b101, 32'd100, 32'd7, 32'd14);
        run_mdu("remu", 3'b111, 32'd100, 32'd7, 32'd2);
`else
        op(2'b10, 3'b100, 7'b0000001, 32'd7, 32'd0);
        tick();
        chk("nodiv valid", {31'b0, u_if.out_valid}, 1);
        chk("nodiv illegal", {31'b0, u_if.illegal_out}, 1);
        chk("nodiv regwrite", {31'b0, u_if.regwrite_out}, 0);
        chk("nodiv alu", u_if.alu_result_out, 0);
        chk("nodiv in_ready", {31'b0, u_if.in_ready}, 1);
`endif

        op(2'b10, 3'b000, 7'b0000001, 32'd9, 32'd9);
        tick();
        u_if.in_valid = 0;
        repeat (10) tick();
        op(2'b10, 3'b000, 7'b0, 32'd1, 32'd1);
        u_if.flush = 1;
        tick();
        idle();
        chk("flush valid", {31'b0, u_if.out_valid}, 0);
        chk("flush in_ready", {31'b0, u_if.in_ready}, 1);
        chk("flush regwrite", {31'b0, u_if.regwrite_out}, 0);
        late = 0;
        repeat (40) begin tick(); if (u_if.out_valid) late++; end
        chk("flush no late", late, 0);

`ifdef EXECUTE_MDU_DIV_EN
        op(2'b10, 3'b100, 7'b0000001, 32'd50, 32'd5);
`else
        op(2'b10, 3'b000, 7'b0000001, 32'd50, 32'd5);
`endif
        tick();
        u_if.in_valid = 0;
        repeat (5) tick();
        reset = 1;
        tick();
        chk("midrst valid", {31'b0, u_if.out_valid}, 0);
        chk("midrst alu", u_if.alu_result_out, 0);
        chk("midrst pc", u_if.pc_out, 0);
        chk("midrst pcimm", u_if.pcimm_out, 0);
        chk("midrst in_ready", {31'b0, u_if.in_ready}, 1);
        reset = 0;
        late = 0;
        repeat (40) begin tick(); if (u_if.out_valid) late++; end
        chk("midrst no late", late, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
